decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with static, auto-scan and single-pulse modes. It is the next generation of the fixed 3-to-8 enable-gated decoder, and it sits between control logic and one-hot select consumers: display row/digit multiplexing, bank selects and strobe fan-out. It adds a registered index, a dwell prescaler for scanning, wrap and error flags, and a range limit for output counts that are not a power of two.

---
 rtl/decoder_pkg.sv | 27 ++
 rtl/decoder_n.sv | 17 +
 rtl/decoder_scan.sv | 117 +++++++++++
 tb/tb_decoder_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
package decoder_pkg;

    localparam int MAX_OUTS = 256;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_SCANNING = 2'd1,
        ST_PULSED   = 2'd2
    } fsm_t;

    // Bit idx set when idx < width; all zero otherwise, so out-of-range never decodes.
    function automatic logic [MAX_OUTS-1:0] onehot(input int unsigned idx, input int unsigned width);
        logic [MAX_OUTS-1:0] v;
        v = '0;
        if (idx < width && idx < MAX_OUTS) v[idx[7:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// Combinational N-to-OUTS one-hot decode with enable; selects >= OUTS give all zero.
module decoder_n
    import decoder_pkg::*;
#(
    parameter int N    = 3,
    parameter int OUTS = 8
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [OUTS-1:0] out
);

    always_comb begin
        out = en ? OUTS'(onehot(32'(sel), 32'(OUTS))) : '0;
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with static hold, dwell-timed auto-scan and single-cycle pulse modes.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int OUTS  = 8,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  mode_t           mode,
    input  logic [N-1:0]    in,
    input  logic            load,
    output logic [OUTS-1:0] out,
    output logic [N-1:0]    idx,
    output logic            wrap,
    output logic            err
);

    localparam int DW = $clog2(DWELL + 1);
    localparam logic [N-1:0]  LAST_IDX  = N'(OUTS - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL - 1);

    if (OUTS > (1 << N) || OUTS < 2 || DWELL < 1) begin : g_bad_params
        $fatal(1, "decoder_scan: illegal N/OUTS/DWELL combination");
    end

    fsm_t          state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          active_q, active_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;
    logic          in_ok;
    logic          load_ok;

    assign in_ok = ({1'b0, in} < (N+1)'(OUTS));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        active_d = active_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        load_ok  = load && in_ok;
        // With ena low everything holds and the strobes stay quiet.
        if (ena) begin
            err_d = load && !in_ok;
            unique case (mode)
                MODE_SCAN: begin
                    state_d  = ST_SCANNING;
                    active_d = 1'b1;
                    if (load_ok) begin
                        idx_d   = in;
                        dwell_d = '0;
                    end else if (state_q != ST_SCANNING) begin
                        dwell_d = '0;
                    end else if (dwell_q == LAST_DWELL) begin
                        dwell_d = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                MODE_PULSE: begin
                    // active lives exactly one cycle per legal load.
                    state_d  = ST_PULSED;
                    active_d = load_ok;
                    if (load_ok) idx_d = in;
                end
                default: begin
                    state_d = ST_HOLD;
                    if (load_ok) begin
                        idx_d    = in;
                        active_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_HOLD;
            idx_q    <= '0;
            dwell_q  <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    decoder_n #(.N(N), .OUTS(OUTS)) u_dec (
        .en  (ena && active_q),
        .sel (idx_q),
        .out (out)
    );

    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed test-plan walk plus randomized traffic against a phase-based reference model.
module tb_decoder_scan;
    import decoder_pkg::*;

    localparam int N = 3, OUTS = 6, DWELL = 3;

    logic            clk = 1'b0;
    logic            rst, ena, load;
    mode_t           mode;
    logic [N-1:0]    in;
    logic [OUTS-1:0] out;
    logic [N-1:0]    idx;
    logic            wrap, err;

    int tests = 0, fails = 0;

    // Reference model: scan position kept as a linear phase in [0, OUTS*DWELL).
    int m_idx, m_phase;
    bit m_active, m_in_scan, m_wrap, m_err;

    decoder_scan #(.N(N), .OUTS(OUTS), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in(in), .load(load),
        .out(out), .idx(idx), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_active = 0; m_in_scan = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit legal;
        m_wrap = 0;
        m_err  = 0;
        if (!ena) return;
        legal = load && (int'(in) < OUTS);
        m_err = load && !legal;
        case (mode)
            MODE_SCAN: begin
                m_active = 1;
                if (legal) m_phase = int'(in) * DWELL;
                else if (!m_in_scan) m_phase = m_idx * DWELL;
                else begin
                    m_phase = (m_phase + 1) % (OUTS * DWELL);
                    m_wrap  = (m_phase == 0);
                end
                m_idx = m_phase / DWELL;
            end
            MODE_PULSE: begin
                m_active = legal;
                if (legal) m_idx = int'(in);
            end
            default: if (legal) begin
                m_idx = int'(in);
                m_active = 1;
            end
        endcase
        m_in_scan = (mode == MODE_SCAN);
    endtask

    task automatic check_all();
        chk("out",  32'(out),  (ena && m_active) ? (32'd1 << m_idx) : 32'd0);
        chk("idx",  32'(idx),  32'(m_idx));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("err",  32'(err),  32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_out",  32'(out),  0);
        chk("rst_idx",  32'(idx),  0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_err",  32'(err),  0);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; load = 1'b0; mode = MODE_STATIC; in = '0;
        model_reset();
        #1 async_reset();
        #4;

        // Static load and hold
        ena = 1'b1; load = 1'b1; in = 3'd4;
        tick();
        chk("t1_out", 32'(out), 32'b010000);
        chk("t1_idx", 32'(idx), 4);
        load = 1'b0;
        repeat (20) tick();
        chk("t1_hold", 32'(out), 32'b010000);

        // Out-of-range load
        load = 1'b1; in = 3'd7;
        tick();
        chk("t2_err", 32'(err), 1);
        chk("t2_out", 32'(out), 32'b010000);
        load = 1'b0;
        tick();
        chk("t2_err_clr", 32'(err), 0);
        chk("t2_idx", 32'(idx), 4);

        // Full scan period from idx 0
        async_reset();
        mode = MODE_SCAN;
        tick();
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) tick();
            chk("t3_out",  32'(out),  32'd1 << ((c / 3) % 6));
            chk("t3_wrap", 32'(wrap), (c == 18) ? 1 : 0);
        end

        // Mid-dwell load at idx 5
        repeat (16) tick();
        chk("t4_pre_idx", 32'(idx), 5);
        load = 1'b1; in = 3'd2;
        tick();
        load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            chk("t4_out",  32'(out),  32'b000100);
            chk("t4_wrap", 32'(wrap), 0);
        end
        tick();
        chk("t4_next", 32'(out), 32'b001000);

        // Back-to-back pulses
        mode = MODE_PULSE; load = 1'b1; in = 3'd1;
        tick();
        chk("t5_p1", 32'(out), 32'b000010);
        in = 3'd3;
        tick();
        chk("t5_p2", 32'(out), 32'b001000);
        load = 1'b0;
        tick();
        chk("t5_off", 32'(out), 0);

        // Freeze mid-scan, resume, then async reset
        mode = MODE_SCAN;
        tick();
        tick();
        ena = 1'b0;
        #1 chk("t6_mask", 32'(out), 0);
        repeat (5) tick();
        chk("t6_frz_idx", 32'(idx), 3);
        ena = 1'b1;
        #1 chk("t6_resume", 32'(out), 32'b001000);
        tick();
        chk("t6_idx3", 32'(idx), 3);
        tick();
        chk("t6_idx4", 32'(idx), 4);
        #2 async_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ena  = ($urandom % 8) != 0;
            mode = mode_t'($urandom_range(0, 3));
            load = ($urandom % 3) == 0;
            in   = N'($urandom_range(0, 7));
            if (($urandom % 4) != 0 && mode == MODE_SCAN) load = 1'b0;
            tick();
            if ($urandom % 97 == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
